// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle PC/fetch sequencer for the RV32 core.
// Owns the PC, walks fetch -> execute -> PC update against instruction
// memory, redirects to the trap vector on misaligned targets or ecall,
// and counts retired instructions.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_FETCH   | imem_req high at pc; waits for imem_ready, pulses inst_valid
// S_EXECUTE | waits for retire, then resolves the next PC or a trap
// S_TRAP    | one cycle: records mepc/trap_cause, loads TRAP_VECTOR
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  next_pc_select,
    input  logic [31:0] immediate,
    input  logic [31:0] jalr_target,
    input  logic        retire,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    output logic        trap_taken,
    output logic [3:0]  trap_cause,
    output logic [31:0] mepc,
    output logic [63:0] instret
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXECUTE = 2'd1,
        S_TRAP    = 2'd2
    } state_t;

    localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] mepc_q, mepc_d;
    logic [3:0]  trap_cause_q, trap_cause_d;
    logic [3:0]  pend_cause_q, pend_cause_d;
    logic [63:0] instret_q, instret_d;
    logic [31:0] target;

    // Candidate next PC from the control-transfer select; adds wrap mod 2^32.
    always_comb begin
        target = pc_q + 32'd4;
        case (next_pc_select)
            2'b00:   target = pc_q + 32'd4;
            2'b01:   target = pc_q + immediate;
            2'b10:   target = jalr_target & 32'hFFFF_FFFE;
            default: target = pc_q + 32'd4;
        endcase
    end

    // Next-state and register updates for the fetch/execute/trap loop.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mepc_d       = mepc_q;
        trap_cause_d = trap_cause_q;
        pend_cause_d = pend_cause_q;
        instret_d    = instret_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (retire) begin
                    if (next_pc_select == 2'b11) begin
                        pend_cause_d = CAUSE_ECALL_M;
                        state_d      = S_TRAP;
                    end else if (target[1:0] != 2'b00) begin
                        pend_cause_d = CAUSE_MISALIGNED;
                        state_d      = S_TRAP;
                    end else begin
                        pc_d      = target;
                        instret_d = instret_q + 64'd1;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_TRAP: begin
                // pc still holds the faulting instruction here
                mepc_d       = pc_q;
                trap_cause_d = pend_cause_q;
                pc_d         = TRAP_VECTOR;
                state_d      = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any instruction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_VECTOR;
            mepc_q       <= 32'd0;
            trap_cause_q <= 4'd0;
            pend_cause_q <= 4'd0;
            instret_q    <= 64'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mepc_q       <= mepc_d;
            trap_cause_q <= trap_cause_d;
            pend_cause_q <= pend_cause_d;
            instret_q    <= instret_d;
        end
    end

    // Handshake pulses are gated by reset so nothing escapes while it is held.
    always_comb begin
        imem_req   = !reset && (state_q == S_FETCH);
        inst_valid = !reset && (state_q == S_FETCH) && imem_ready;
        trap_taken = !reset && (state_q == S_TRAP);
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign pc_plus_4  = pc_q + 32'd4;
    assign trap_cause = trap_cause_q;
    assign mepc       = mepc_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by randomized
// instruction streams, checked cycle by cycle against a transaction-level model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_VEC = 32'h0040_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0010;

    logic        clock;
    logic        reset;
    logic [1:0]  next_pc_select;
    logic [31:0] immediate;
    logic [31:0] jalr_target;
    logic        retire;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        trap_taken;
    logic [3:0]  trap_cause;
    logic [31:0] mepc;
    logic [63:0] instret;

    pc_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .next_pc_select (next_pc_select),
        .immediate      (immediate),
        .jalr_target    (jalr_target),
        .retire         (retire),
        .imem_ready     (imem_ready),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .inst_valid     (inst_valid),
        .pc             (pc),
        .pc_plus_4      (pc_plus_4),
        .trap_taken     (trap_taken),
        .trap_cause     (trap_cause),
        .mepc           (mepc),
        .instret        (instret)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;

    // architectural model state
    logic [31:0] m_pc;
    logic [31:0] m_mepc;
    logic [3:0]  m_cause;
    logic [63:0] m_instret;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset;
        m_pc      = RESET_VEC;
        m_mepc    = 32'd0;
        m_cause   = 4'd0;
        m_instret = 64'd0;
    endtask

    // One full instruction: fw stall cycles in fetch, ew wait cycles in execute,
    // then retire with the given control-transfer inputs.
    task automatic run_instr(input int fw, input int ew, input logic [1:0] sel,
                             input logic [31:0] imm, input logic [31:0] jt,
                             input logic rdy_in_exec);
        logic [31:0] tgt;
        logic        is_trap;
        chk("pc_start", {32'd0, pc}, {32'd0, m_pc});
        chk("instret_start", instret, m_instret);
        chk("mepc_start", {32'd0, mepc}, {32'd0, m_mepc});
        chk("cause_start", {60'd0, trap_cause}, {60'd0, m_cause});
        for (int i = 0; i < fw; i++) begin
            imem_ready     = 1'b0;
            retire         = 1'($urandom_range(0, 1));
            next_pc_select = 2'($urandom_range(0, 3));
            #1;
            chk("fetch_req", {63'd0, imem_req}, 64'd1);
            chk("fetch_addr", {32'd0, imem_addr}, {32'd0, m_pc});
            chk("fetch_novalid", {63'd0, inst_valid}, 64'd0);
            tick();
        end
        imem_ready = 1'b1;
        retire     = 1'($urandom_range(0, 1));
        #1;
        chk("inst_valid", {63'd0, inst_valid}, 64'd1);
        chk("fetch_req_rdy", {63'd0, imem_req}, 64'd1);
        chk("fetch_addr_rdy", {32'd0, imem_addr}, {32'd0, m_pc});
        tick();
        retire = 1'b0;
        for (int i = 0; i < ew; i++) begin
            imem_ready = rdy_in_exec ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            chk("exec_noreq", {63'd0, imem_req}, 64'd0);
            chk("exec_novalid", {63'd0, inst_valid}, 64'd0);
            chk("exec_pc", {32'd0, pc}, {32'd0, m_pc});
            chk("pc_plus_4", {32'd0, pc_plus_4}, {32'd0, m_pc + 32'd4});
            tick();
        end
        imem_ready     = rdy_in_exec ? 1'b1 : 1'($urandom_range(0, 1));
        retire         = 1'b1;
        next_pc_select = sel;
        immediate      = imm;
        jalr_target    = jt;
        #1;
        chk("retire_novalid", {63'd0, inst_valid}, 64'd0);
        tick();
        retire     = 1'b0;
        imem_ready = 1'b0;

        case (sel)
            2'b00:   tgt = m_pc + 32'd4;
            2'b01:   tgt = m_pc + imm;
            2'b10:   tgt = {jt[31:1], 1'b0};
            default: tgt = 32'd0;
        endcase
        is_trap = (sel == 2'b11) || (tgt[1:0] != 2'b00);
        if (is_trap) begin
            #1;
            chk("trap_pulse", {63'd0, trap_taken}, 64'd1);
            chk("trap_pc_hold", {32'd0, pc}, {32'd0, m_pc});
            chk("trap_noreq", {63'd0, imem_req}, 64'd0);
            tick();
            m_mepc  = m_pc;
            m_cause = (sel == 2'b11) ? 4'd11 : 4'd0;
            m_pc    = TRAP_VEC;
        end else begin
            m_pc      = tgt;
            m_instret = m_instret + 64'd1;
        end
        #1;
        chk("trap_done", {63'd0, trap_taken}, 64'd0);
        chk("pc_next", {32'd0, pc}, {32'd0, m_pc});
        chk("instret_next", instret, m_instret);
        chk("mepc_next", {32'd0, mepc}, {32'd0, m_mepc});
        chk("cause_next", {60'd0, trap_cause}, {60'd0, m_cause});
        chk("req_next", {63'd0, imem_req}, 64'd1);
    endtask

    initial begin
        logic [31:0] r_imm;
        logic [31:0] r_jt;
        logic [1:0]  r_sel;
        reset          = 1'b1;
        next_pc_select = 2'b00;
        immediate      = 32'd0;
        jalr_target    = 32'd0;
        retire         = 1'b0;
        imem_ready     = 1'b1;
        model_reset();

        // reset held for three cycles; handshakes stay quiet
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_noreq", {63'd0, imem_req}, 64'd0);
            chk("rst_novalid", {63'd0, inst_valid}, 64'd0);
            chk("rst_notrap", {63'd0, trap_taken}, 64'd0);
        end
        reset      = 1'b0;
        imem_ready = 1'b0;
        #1;
        chk("rel_req", {63'd0, imem_req}, 64'd1);
        chk("rel_pc", {32'd0, pc}, {32'd0, 32'h0040_0000});
        chk("rel_instret", instret, 64'd0);

        // straight-line code, zero stalls
        for (int i = 0; i < 3; i++) run_instr(0, 0, 2'b00, 32'd0, 32'd0, 1'b0);
        chk("seq_pc", {32'd0, pc}, {32'd0, 32'h0040_000C});
        chk("seq_instret", instret, 64'd3);

        // branch backwards, then JALR with low bit cleared
        run_instr(1, 1, 2'b10, 32'd0, 32'h0040_0010, 1'b0);
        run_instr(0, 2, 2'b01, 32'hFFFF_FFF8, 32'd0, 1'b0);
        chk("branch_back", {32'd0, pc}, {32'd0, 32'h0040_0008});
        run_instr(2, 0, 2'b10, 32'd0, 32'h0040_0101, 1'b0);
        chk("jalr_mask", {32'd0, pc}, {32'd0, 32'h0040_0100});

        // misaligned JALR target traps, then ecall
        run_instr(0, 0, 2'b10, 32'd0, 32'h0040_000C, 1'b0);
        run_instr(0, 0, 2'b10, 32'd0, 32'h0040_0103, 1'b0);
        chk("mis_mepc", {32'd0, mepc}, {32'd0, 32'h0040_000C});
        chk("mis_cause", {60'd0, trap_cause}, 64'd0);
        chk("mis_pc", {32'd0, pc}, {32'd0, 32'h0000_0010});
        chk("mis_instret", instret, 64'd7);
        run_instr(0, 1, 2'b11, 32'd0, 32'd0, 1'b0);
        chk("ecall_cause", {60'd0, trap_cause}, 64'd11);
        chk("ecall_mepc", {32'd0, mepc}, {32'd0, 32'h0000_0010});

        // PC wrap at the top of the address space
        run_instr(0, 0, 2'b10, 32'd0, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_p4", {32'd0, pc_plus_4}, 64'd0);
        run_instr(0, 1, 2'b00, 32'd0, 32'd0, 1'b0);
        chk("wrap_pc", {32'd0, pc}, 64'd0);

        // imem_ready held high throughout execute gives no extra fetch pulse
        run_instr(0, 3, 2'b00, 32'd0, 32'd0, 1'b1);

        // reset lands in execute together with retire
        imem_ready = 1'b1;
        #1;
        chk("r6_valid", {63'd0, inst_valid}, 64'd1);
        tick();
        imem_ready     = 1'b1;
        retire         = 1'b1;
        next_pc_select = 2'b00;
        reset          = 1'b1;
        #1;
        chk("r6_noreq", {63'd0, imem_req}, 64'd0);
        chk("r6_novalid", {63'd0, inst_valid}, 64'd0);
        tick();
        retire = 1'b0;
        #1;
        chk("r6_pc", {32'd0, pc}, {32'd0, RESET_VEC});
        chk("r6_instret", instret, 64'd0);
        chk("r6_notrap", {63'd0, trap_taken}, 64'd0);
        tick();
        reset      = 1'b0;
        imem_ready = 1'b0;
        model_reset();
        #1;

        // randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            r_sel = 2'($urandom_range(0, 3));
            r_imm = $urandom();
            if ($urandom_range(0, 3) != 0) r_imm[1:0] = 2'b00;
            r_jt  = $urandom();
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      r_sel, r_imm, r_jt, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
